// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scanner with prescaler, anti-ghost blanking and
// frame-synchronous shadow update. Optional PWM dimming: define SEG7_SCAN_PWM_EN.
module seg7_scan_driver #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter bit SEG_INV   = 1'b0,
  parameter bit SEL_INV   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  lz_blank,
  input  logic                  load,
`ifdef SEG7_SCAN_PWM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [PW-1:0]     P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]     P_BLANK = PW'(BLANK_CYC);
  localparam logic [IW-1:0]     I_LAST  = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF = SEG_INV ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = SEL_INV ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]       prescaler_reg;
  logic [IW-1:0]       idx_reg;
  logic [4*DIGITS-1:0] pend_val_reg, active_val_reg;
  logic [DIGITS-1:0]   pend_en_reg, active_en_reg;
  logic [DIGITS-1:0]   pend_dots_reg, active_dots_reg;
  logic                pend_valid_reg;
  logic [7:0]          seg_reg, seg_next;
  logic [DIGITS-1:0]   sel_reg, sel_next;
  logic                frame_done_reg;
  logic                frame_end;
  logic [DIGITS-1:0]   upper_zero;
  logic [3:0]          cur_nib;
  logic                cur_blank;
  logic [6:0]          seg_main;

`ifdef SEG7_SCAN_PWM_EN
  logic [3:0]          pwm_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt_reg <= 4'd0;
    else     pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
  end
`endif

  assign frame_end = (prescaler_reg == P_LAST) && (idx_reg == I_LAST);

  // upper_zero[i]: digit i and every more significant digit hold zero
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign upper_zero[gi] = ~|active_val_reg[4*DIGITS-1:4*gi];
    end
  endgenerate

  always_comb begin
    cur_nib   = active_val_reg[{idx_reg, 2'b00} +: 4];
    cur_blank = !active_en_reg[idx_reg] ||
                (lz_blank && (idx_reg != '0) && upper_zero[idx_reg]);
    seg_main  = 7'h00;
    if (!cur_blank) begin
      case (cur_nib)
        4'h0: seg_main = 7'h3F;
        4'h1: seg_main = 7'h06;
        4'h2: seg_main = 7'h5B;
        4'h3: seg_main = 7'h4F;
        4'h4: seg_main = 7'h66;
        4'h5: seg_main = 7'h6D;
        4'h6: seg_main = 7'h7D;
        4'h7: seg_main = 7'h07;
        4'h8: seg_main = 7'h7F;
        4'h9: seg_main = 7'h6F;
        4'hA: seg_main = 7'h77;
        4'hB: seg_main = 7'h7C;
        4'hC: seg_main = 7'h39;
        4'hD: seg_main = 7'h5E;
        4'hE: seg_main = 7'h79;
        default: seg_main = 7'h71;
      endcase
    end
  end

  always_comb begin
    seg_next = SEG_OFF;
    sel_next = SEL_OFF;
    if (prescaler_reg >= P_BLANK) begin
      seg_next = {active_dots_reg[idx_reg], seg_main} ^ SEG_OFF;
      sel_next = (DIGITS'(1) << idx_reg) ^ SEL_OFF;
`ifdef SEG7_SCAN_PWM_EN
      if (pwm_cnt_reg > brightness) sel_next = SEL_OFF;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_reg   <= '0;
      idx_reg         <= '0;
      pend_val_reg    <= '0;
      pend_en_reg     <= '0;
      pend_dots_reg   <= '0;
      pend_valid_reg  <= 1'b0;
      active_val_reg  <= '0;
      active_en_reg   <= '0;
      active_dots_reg <= '0;
      seg_reg         <= SEG_OFF;
      sel_reg         <= SEL_OFF;
      frame_done_reg  <= 1'b0;
    end else begin
      if (prescaler_reg == P_LAST) begin
        prescaler_reg <= '0;
        idx_reg       <= (idx_reg == I_LAST) ? '0 : idx_reg + IW'(1);
      end else begin
        prescaler_reg <= prescaler_reg + PW'(1);
      end
      frame_done_reg <= frame_end;
      if (frame_end && pend_valid_reg) begin
        active_val_reg  <= pend_val_reg;
        active_en_reg   <= pend_en_reg;
        active_dots_reg <= pend_dots_reg;
        pend_valid_reg  <= 1'b0;
      end
      // a load on the frame-end edge lands in pending after the old pending moved on
      if (load) begin
        pend_val_reg   <= value;
        pend_en_reg    <= digit_en;
        pend_dots_reg  <= dots;
        pend_valid_reg <= 1'b1;
      end
      seg_reg <= seg_next;
      sel_reg <= sel_next;
    end
  end

  assign seg        = seg_reg;
  assign sel        = sel_reg;
  assign frame_done = frame_done_reg;

endmodule
